// File: rtl/mvc_pkg.sv
// rtl/mvc_pkg.sv - shared types and constants for the max value counter
package mvc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    FINISH = 2'd2
  } mvc_state_t;

  localparam int LIMIT_W_DEF = 6;

  // Matches the upstream max_value constant (20)
  localparam logic [5:0] LIMIT_DEF = 6'h14;

endpackage

// File: rtl/max_value_counter.sv
// rtl/max_value_counter.sv - latches a limit on start, counts accepted beats, pulses wrap and done
module max_value_counter
  import mvc_pkg::*;
#(
  parameter int LIMIT_W = LIMIT_W_DEF,
  parameter int WRAPS   = 3,
  parameter int IN_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_W-1:0]    limit_in,
  input  logic               start,
  input  logic               inc_valid,
  output logic               inc_ready,
  output logic [LIMIT_W-1:0] count,
  output logic               wrap,
  output logic               done,
  output logic               busy,
  output logic               sat_err
);

  mvc_state_t         state;
  mvc_state_t         next_state;
  logic [LIMIT_W-1:0] lim;
  logic [3:0]         wrap_cnt;

  logic               over;
  logic [LIMIT_W-1:0] sel_lim;
  logic               accept;
  logic               last_beat;
  logic               last_wrap;

  // A limit wider than the counter saturates to all-ones instead of truncating
  assign over    = |limit_in[IN_W-1:LIMIT_W];
  assign sel_lim = over ? '1 : limit_in[LIMIT_W-1:0];

  assign inc_ready = (state == COUNT);
  assign busy      = (state == COUNT);
  assign accept    = inc_valid && (state == COUNT);
  assign last_beat = (count == lim - LIMIT_W'(1));
  assign last_wrap = (wrap_cnt == 4'(WRAPS - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (sel_lim == '0) ? FINISH : COUNT;
        end
      end
      COUNT: begin
        if (accept && last_beat && last_wrap) begin
          next_state = FINISH;
        end
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lim      <= LIMIT_W'(LIMIT_DEF);
      count    <= '0;
      wrap_cnt <= '0;
      wrap     <= 1'b0;
      done     <= 1'b0;
      sat_err  <= 1'b0;
    end else begin
      state <= next_state;
      wrap  <= 1'b0;
      // done trails the FINISH state by one edge, like wrap trails its beat
      done  <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            lim      <= sel_lim;
            count    <= '0;
            wrap_cnt <= '0;
            if (over) begin
              sat_err <= 1'b1;
            end
          end
        end
        COUNT: begin
          if (accept) begin
            if (last_beat) begin
              count    <= '0;
              wrap     <= 1'b1;
              wrap_cnt <= wrap_cnt + 4'd1;
            end else begin
              count <= count + LIMIT_W'(1);
            end
          end
        end
        FINISH: begin
          count <= '0;
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_value_counter.sv
// tb/tb_max_value_counter.sv - randomized scoreboard bench for max_value_counter
module tb_max_value_counter;
  localparam int LIMIT_W = 6;
  localparam int WRAPS   = 3;
  localparam int IN_W    = 32;
  localparam int MAXL    = (1 << LIMIT_W) - 1;
  localparam int K_WRAP  = 1;
  localparam int K_DONE  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [IN_W-1:0]    limit_in;
  logic               start;
  logic               inc_valid;
  logic               inc_ready;
  logic [LIMIT_W-1:0] count;
  logic               wrap;
  logic               done;
  logic               busy;
  logic               sat_err;

  max_value_counter #(.LIMIT_W(LIMIT_W), .WRAPS(WRAPS), .IN_W(IN_W)) dut (
    .clk(clk), .rst_n(rst_n), .limit_in(limit_in), .start(start),
    .inc_valid(inc_valid), .inc_ready(inc_ready), .count(count),
    .wrap(wrap), .done(done), .busy(busy), .sat_err(sat_err)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  int vectors = 0;
  int errors  = 0;

  // Reference model: a run is lim*WRAPS accepted beats; every lim-th beat is a wrap
  bit m_running;
  int m_lim;
  int m_beats;
  int m_ready_edge;
  bit m_sat;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int cyc);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_running    = 1'b0;
    m_lim        = 0;
    m_beats      = 0;
    m_ready_edge = 0;
    m_sat        = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input int e, input logic s, input logic v, input logic [IN_W-1:0] lb);
    if (m_running) begin
      if (v) begin
        m_beats++;
        if (m_beats % m_lim == 0) push_ev(K_WRAP, e);
        if (m_beats == m_lim * WRAPS) begin
          push_ev(K_DONE, e + 1);
          m_running    = 1'b0;
          m_ready_edge = e + 2;
        end
      end
    end else if (e >= m_ready_edge && s) begin
      m_lim   = (lb > IN_W'(MAXL)) ? MAXL : int'(lb);
      if (lb > IN_W'(MAXL)) m_sat = 1'b1;
      m_beats = 0;
      if (m_lim == 0) begin
        push_ev(K_DONE, e + 1);
        m_ready_edge = e + 2;
      end else begin
        m_running = 1'b1;
      end
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [IN_W-1:0] lb);
    start     = s;
    inc_valid = v;
    limit_in  = lb;
    @(posedge clk);
    #1;
    model_edge(edge_n, s, v, lb);
    chk("count", int'(count), m_running ? (m_beats % m_lim) : 0);
    chk("busy", int'(busy), int'(m_running));
    chk("inc_ready", int'(inc_ready), int'(m_running));
    chk("sat_err", int'(sat_err), int'(m_sat));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    inc_valid = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_inc_ready", int'(inc_ready), 0);
    chk("rst_sat_err", int'(sat_err), 0);
    rst_n = 1'b1;
  endtask

  // mode 0: valid held, 1: toggled, 2: random, 3: random valid plus stray starts and limit changes
  task automatic run(input logic [IN_W-1:0] lb, input int mode);
    int  guard;
    bit  tog;
    logic v;
    logic s;
    logic [IN_W-1:0] l;
    guard = 0;
    tog   = 1'b1;
    step(1'b1, 1'($urandom_range(0, 1)), lb);
    while ((m_running || edge_n < m_ready_edge) && guard < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      s = (mode == 3 && m_running) ? 1'($urandom_range(0, 1)) : 1'b0;
      l = (mode == 3) ? IN_W'(5) : lb;
      step(s, v, l);
      guard++;
    end
    if (guard >= 2000) chk("run_timeout", guard, 0);
    step(1'b0, 1'b0, lb);
    step(1'b0, 1'b1, lb);
  endtask

  always @(negedge clk) begin
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
      e = exp_q.pop_front();
      chk("missed_pulse_kind", 0, e.kind);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
      e = exp_q.pop_front();
      chk("wrap_pulse", int'(wrap), int'(e.kind == K_WRAP));
      chk("done_pulse", int'(done), int'(e.kind == K_DONE));
    end else if (wrap === 1'b1 || done === 1'b1) begin
      chk("spurious_pulse", int'({wrap, done}), 0);
    end
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    inc_valid = 1'b0;
    limit_in  = 32'd20;
    model_reset();
    do_reset();
    do_reset();

    run(32'd20, 0);
    run(32'd20, 1);
    run(32'd100, 0);
    run(32'd0, 2);
    do_reset();

    step(1'b1, 1'b0, 32'd20);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 32'd20);
    chk("count_before_reset", int'(count), 7);
    do_reset();
    run(32'd20, 0);

    run(32'd20, 3);

    for (int i = 0; i < 12; i++) begin
      logic [IN_W-1:0] lb;
      case ($urandom_range(0, 3))
        0:       lb = IN_W'($urandom_range(0, 3));
        1:       lb = IN_W'($urandom_range(60, 70));
        2:       lb = $urandom;
        default: lb = IN_W'($urandom_range(1, 30));
      endcase
      if (lb > 32'd200) lb = lb | 32'h0001_0000;
      if (lb > 32'd63 && $urandom_range(0, 1) == 0) lb = IN_W'($urandom_range(1, 12));
      run(lb, 2);
      if ($urandom_range(0, 3) == 0) do_reset();
    end

    step(1'b0, 1'b0, 32'd20);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
